alu_result_fifo: RTL

Downstream capture stage for the 4-bit ALU. It accepts each 8-bit `ALUOut` result with a valid/ready handshake and holds results in a small circular FIFO. It presents the oldest result to the display/consumer stage through its own valid/ready handshake, so ALU results computed faster than the consumer can take them are buffered rather than lost.

---
 rtl/alu_result_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//
// Capture stage behind the 4-bit ALU. Each 8-bit ALU result is accepted over
// a valid/ready handshake and held in a small circular FIFO. The oldest
// result is offered to the display/consumer stage over a second valid/ready
// handshake. Results that the ALU produces faster than the consumer can take
// them are buffered, not lost.
//
// Parameters:
//   DEPTH      number of 8-bit entries (power of 2, >= 2), default 4
//
// Ports:
//   Clock      in   1               rising-edge clock for all state
//   Reset      in   1               synchronous active-high reset
//   ALUOut     in   8               result word from the ALU
//   InValid    in   1               ALUOut holds a result to capture
//   InReady    out  1               FIFO can accept a word (Count != DEPTH)
//   OutData    out  8               oldest stored result, 8'h00 when empty
//   OutValid   out  1               OutData is valid (Count != 0)
//   OutReady   in   1               consumer takes OutData this cycle
//   Count      out  $clog2(DEPTH)+1 number of stored entries, 0..DEPTH
//   DropCount  out  8               saturating count of pushes attempted
//                                   while full. This port exists only when
//                                   ALU_RESULT_FIFO_DROP_CNT_EN is defined.
//
// Configuration macro: ALU_RESULT_FIFO_DROP_CNT_EN
//
// All outputs come from registers. OutData is kept in its own register and
// reloaded only when the head of the queue changes, which is on a pop or on
// a push into an empty FIFO. For that reason the output never combinationally
// follows the storage array or ALUOut.
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               ALUOut,
    input  logic                     InValid,
    output logic                     InReady,
    output logic [7:0]               OutData,
    output logic                     OutValid,
    input  logic                     OutReady,
`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
    output logic [7:0]               DropCount,
`endif
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_EMPTY = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Occupancy classes derived from the count. They are not a separate
    // state register.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    // Storage and state
    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       out_data_r;
    logic             in_ready_r;
    logic             out_valid_r;

    // Next-state and handshake signals
    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] rd_ptr_inc_s;
    logic [PTR_W-1:0] wr_ptr_inc_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [7:0]       out_data_nxt_s;
    occ_e             occ_nxt_s;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;

    // Handshakes qualified by the registered ready/valid flags. Because of
    // this, a push is refused when full even if a pop happens in the same cycle.
    always_comb begin
        push_s       = InValid && in_ready_r;
        pop_s        = out_valid_r && OutReady;
        rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
        wr_ptr_inc_s = wr_ptr_r + PTR_ONE;
    end

    // Occupancy update: push only +1, pop only -1, both or neither hold
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Classify the next occupancy so the ready/valid flags can be registered
    always_comb begin
        occ_nxt_s = OCC_PARTIAL;
        if (count_nxt_s == CNT_EMPTY) begin
            occ_nxt_s = OCC_EMPTY;
        end else if (count_nxt_s == CNT_FULL) begin
            occ_nxt_s = OCC_FULL;
        end else begin
            occ_nxt_s = OCC_PARTIAL;
        end
    end

    // Map the occupancy class to the next ready/valid flag values
    always_comb begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b1;
        case (occ_nxt_s)
            OCC_EMPTY: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
            OCC_FULL: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
            end
            OCC_PARTIAL: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Next head-of-queue word. After a pop the new head is the entry behind
    // the read pointer. When only one word remained, the new head is either
    // the word pushed on the same edge or nothing (8'h00).
    always_comb begin
        out_data_nxt_s = out_data_r;
        if (pop_s) begin
            if (count_r == CNT_ONE) begin
                if (push_s) begin
                    out_data_nxt_s = ALUOut;
                end else begin
                    out_data_nxt_s = 8'h00;
                end
            end else begin
                out_data_nxt_s = mem_r[rd_ptr_inc_s];
            end
        end else if (push_s && (count_r == CNT_EMPTY)) begin
            out_data_nxt_s = ALUOut;
        end else begin
            out_data_nxt_s = out_data_r;
        end
    end

    // Storage array write. The array has no reset because its contents are
    // qualified by Count.
    always_ff @(posedge Clock) begin
        if (push_s && !Reset) begin
            mem_r[wr_ptr_r] <= ALUOut;
        end
    end

    // Pointer, occupancy and registered-output update. Reset wins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= CNT_EMPTY;
            out_data_r  <= 8'h00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_inc_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            count_r     <= count_nxt_s;
            out_data_r  <= out_data_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

`ifdef ALU_RESULT_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Saturating count of pushes refused because the FIFO was full
    always_ff @(posedge Clock) begin
        if (Reset) begin
            drop_cnt_r <= 8'h00;
        end else if (InValid && !in_ready_r && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'h01;
        end
    end

    assign DropCount = drop_cnt_r;
`endif

    assign InReady  = in_ready_r;
    assign OutValid = out_valid_r;
    assign OutData  = out_data_r;
    assign Count    = count_r;

endmodule
